// File: rtl/mert_pkg.sv
// mert_pkg
//   Shared constants and helpers for the pipelined Montgomery multiplier.
//   DEF_*    : default modulus and pipeline shape (NTT prime 2^31+2^25+2^11+1)
//   round_w  : width of the value leaving reduction round i (round 0 = raw product)
//   pow2_mod : 2^e mod q, evaluated at elaboration
//   R2       : 2^(2*S*ROUNDS) mod Q; multiply by this to enter the Montgomery domain
package mert_pkg;

  localparam int          DEF_W      = 32;
  localparam logic [63:0] DEF_Q      = 64'd2181040129;
  localparam int          DEF_S      = 11;
  localparam int          DEF_ROUNDS = 3;
  localparam int          DEF_TAG_W  = 8;

  // Each round retires S bits and keeps one guard bit, but the value never
  // drops below W+1 bits because it is bounded by 2Q from then on.
  function automatic int round_w(input int w, input int s, input int i);
    int r;
    if (i == 0) begin
      r = 2 * w;
    end else begin
      r = 2 * w - i * s + 1;
      if (r < w + 1) r = w + 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] pow2_mod(input logic [63:0] q, input int e);
    logic [63:0] r;
    r = 64'd1 % q;
    for (int k = 0; k < e; k++) begin
      r = r << 1;
      if (r >= q) r = r - q;
    end
    return r;
  endfunction

  localparam logic [63:0] R2 = pow2_mod(DEF_Q, 2 * DEF_S * DEF_ROUNDS);

endpackage

// File: rtl/mert_reduce_stage.sv
// mert_reduce_stage
//   One registered Montgomery reduction round: T' = (T + m*Q) >> S with
//   m = -T mod 2^S, so the low S bits of the sum are zero and the shift is exact.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     en               global pipeline advance enable
//     in_valid, in_t   incoming valid bit and value (IN_W bits)
//     out_valid, out_t registered valid bit and reduced value (OUT_W bits)
module mert_reduce_stage
  import mert_pkg::*;
#(
  parameter int          IN_W  = 64,
  parameter int          OUT_W = 54,
  parameter int          S     = DEF_S,
  parameter int          QW    = DEF_W,
  parameter logic [63:0] Q     = DEF_Q
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_t,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_t
);

  // One extra bit over the larger addend so T + m*Q cannot overflow.
  localparam int SUM_W = ((IN_W > QW + S) ? IN_W : QW + S) + 1;
  localparam logic [SUM_W-1:0] Q_EXT = SUM_W'(Q);

  logic [S-1:0]     m;
  logic [SUM_W-1:0] sum;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] t_q, t_d;

  always_comb begin
    m   = (~in_t[S-1:0]) + S'(1);
    sum = SUM_W'(in_t) + SUM_W'(m) * Q_EXT;
  end

  always_comb begin
    valid_d = valid_q;
    t_d     = t_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) t_d = OUT_W'(sum >> S);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      t_q     <= '0;
    end else begin
      valid_q <= valid_d;
      t_q     <= t_d;
    end
  end

  assign out_valid = valid_q;
  assign out_t     = t_q;

endmodule

// File: rtl/mert_modmul_pipe.sv
// mert_modmul_pipe
//   Fully pipelined Montgomery modular multiplier, R = A*B*2^(-S*ROUNDS) mod Q,
//   one result per clock, latency ROUNDS+3 from accept to out_valid.
//   Stages: P0 operand regs, P1 product, ROUNDS reduction rounds, final subtract.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     in_valid/in_ready           operand handshake; in_a, in_b < Q, in_tag sideband
//     out_valid/out_ready         result handshake; out_r in [0,Q-1], out_tag echoed
module mert_modmul_pipe
  import mert_pkg::*;
#(
  parameter int          W      = DEF_W,
  parameter logic [63:0] Q      = DEF_Q,
  parameter int          S      = DEF_S,
  parameter int          ROUNDS = DEF_ROUNDS,
  parameter int          TAG_W  = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int TW   = round_w(W, S, ROUNDS);
  localparam int LAST = ROUNDS - 1;
  localparam logic [TW:0] Q_FIN = (TW + 1)'(Q);

  if (Q[S-1:0] != S'(1)) begin : g_bad_q_low
    $fatal(1, "mert_modmul_pipe: Q mod 2^S must be 1");
  end
  if ((Q >> W) != 64'd0) begin : g_bad_q_range
    $fatal(1, "mert_modmul_pipe: Q must be below 2^W");
  end
  if (S * ROUNDS < W) begin : g_bad_rounds
    $fatal(1, "mert_modmul_pipe: S*ROUNDS must be at least W");
  end

  logic             en;
  logic             started_q, started_d;
  logic             v0_q, v0_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag0_q, tag0_d;
  logic             v1_q, v1_d;
  logic [2*W-1:0]   c_q, c_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_r_q, out_r_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // Single advance enable for the whole pipe: everything moves or everything holds.
  assign en = ~out_valid_q | out_ready;
  // started_q keeps the block from accepting until the first edge after reset.
  assign in_ready = en & started_q;

  always_comb begin
    started_d = 1'b1;
    v0_d      = v0_q;
    a_d       = a_q;
    b_d       = b_q;
    tag0_d    = tag0_q;
    if (en) begin
      v0_d = in_valid & started_q;
      if (in_valid & started_q) begin
        a_d    = in_a;
        b_d    = in_b;
        tag0_d = in_tag;
      end
    end
  end

  always_comb begin
    v1_d   = v1_q;
    c_d    = c_q;
    tag1_d = tag1_q;
    if (en) begin
      v1_d = v0_q;
      if (v0_q) begin
        c_d    = (2 * W)'(a_q) * (2 * W)'(b_q);
        tag1_d = tag0_q;
      end
    end
  end

  for (genvar i = 0; i < ROUNDS; i++) begin : g_round
    localparam int IN_W  = round_w(W, S, i);
    localparam int OUT_W = round_w(W, S, i + 1);

    logic             v_in;
    logic [IN_W-1:0]  t_in;
    logic [TAG_W-1:0] tag_in;
    logic             v_out;
    logic [OUT_W-1:0] t_out;
    logic [TAG_W-1:0] tag_q, tag_d;

    if (i == 0) begin : g_first
      assign v_in   = v1_q;
      assign t_in   = c_q;
      assign tag_in = tag1_q;
    end else begin : g_next
      assign v_in   = g_round[i-1].v_out;
      assign t_in   = g_round[i-1].t_out;
      assign tag_in = g_round[i-1].tag_q;
    end

    mert_reduce_stage #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .S    (S),
      .QW   (W),
      .Q    (Q)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (v_in),
      .in_t     (t_in),
      .out_valid(v_out),
      .out_t    (t_out)
    );

    always_comb begin
      tag_d = tag_q;
      if (en && v_in) tag_d = tag_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= tag_d;
    end
  end

  logic             v_fin;
  logic [TW-1:0]    t_fin;
  logic [TAG_W-1:0] tag_fin;
  logic [TW:0]      diff;
  logic [W-1:0]     res;

  assign v_fin   = g_round[LAST].v_out;
  assign t_fin   = g_round[LAST].t_out;
  assign tag_fin = g_round[LAST].tag_q;

  // The last round leaves T < 2Q, so one conditional subtract lands in [0,Q-1].
  always_comb begin
    diff = {1'b0, t_fin} - Q_FIN;
    res  = diff[TW] ? W'(t_fin) : W'(diff);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_tag_d   = out_tag_q;
    if (en) begin
      out_valid_d = v_fin;
      if (v_fin) begin
        out_r_d   = res;
        out_tag_d = tag_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q   <= 1'b0;
      v0_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag0_q      <= '0;
      v1_q        <= 1'b0;
      c_q         <= '0;
      tag1_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      started_q   <= started_d;
      v0_q        <= v0_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag0_q      <= tag0_d;
      v1_q        <= v1_d;
      c_q         <= c_d;
      tag1_q      <= tag1_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;

endmodule
